quickq_req_arbiter: RTL and testbench
=====================================

QUICKQ_REQ_ARBITER -- requirements
Module: quickq_req_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesting clients; legal range 2 to 8.
REQ-002 Parameter W, default 8, data word width; SHALL match the QuickQ instance.
REQ-003 Parameter TMO, default 255, maximum cycles spent waiting for q_done before abort.
REQ-004 clk  in  1  clock; all state SHALL update on posedge clk only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  N  per-client request pending.
REQ-007 req_op  in  N  per-client operation: 0 = enqueue, 1 = dequeue.
REQ-008 req_data  in  N*W  per-client enqueue word; client i occupies bits [i*W +: W].
REQ-009 req_ready  out  N  one-hot request accept strobe, one cycle.
REQ-010 rsp_valid  out  N  one-hot completion strobe, one cycle.
REQ-011 rsp_data  out  W  dequeued word; valid with rsp_valid.
REQ-012 rsp_err  out  1  completion status: 1 = rejected or timed out; valid with rsp_valid.
REQ-013 q_enq, q_deq  out  1 each  single-cycle command pulses to the QuickQ controller.
REQ-014 q_din  out  W  enqueue word; held stable from the q_enq pulse until completion.
REQ-015 q_done  in  1  operation complete pulse from QuickQ.
REQ-016 q_dout  in  W  dequeued word; valid with q_done.
REQ-017 q_full, q_empty  in  1 each  QuickQ occupancy flags.

Function
REQ-018 States: IDLE, GRANT, ISSUE, WAIT, RESP. Encoding is free.
REQ-019 IDLE: if any req_valid is set, latch the winner index, op, and data, then go to GRANT; otherwise stay in IDLE.
REQ-020 Arbitration: round-robin. Search starts at rr_ptr and proceeds upward with wrap from N-1 to 0.
REQ-021 After each grant, rr_ptr SHALL be set to (winner+1) mod N.
REQ-022 GRANT: assert req_ready[winner] for exactly 1 cycle.
  - If (op=enq and q_full) or (op=deq and q_empty): set err_flag and go to RESP.
  - Otherwise go to ISSUE.
REQ-023 ISSUE: assert q_enq or q_deq for exactly 1 cycle, clear the timeout counter, and go to WAIT.
REQ-024 WAIT: increment the timeout counter each cycle.
  - On q_done: capture q_dout (dequeue only), clear err_flag, go to RESP.
  - If the counter reaches TMO without q_done: set err_flag and go to RESP.
REQ-025 RESP: assert rsp_valid[winner] for exactly 1 cycle with rsp_err = err_flag, then go to IDLE.
REQ-026 Latency from req_ready to q_enq or q_deq SHALL be exactly 1 cycle.
REQ-027 Latency from q_done to rsp_valid SHALL be exactly 1 cycle.
REQ-028 Minimum request-to-response time is 4 cycles plus the QuickQ latency.
REQ-029 q_done outside WAIT SHALL be ignored.
REQ-030 At most one QuickQ operation SHALL be outstanding at any time.
REQ-031 Requests arriving while not in IDLE SHALL wait. A client SHALL hold req_valid, req_op, and req_data until its req_ready.
REQ-032 rsp_data SHALL hold its last captured value. It is 0 for rejected operations and for enqueues.
REQ-033 The timeout counter SHALL be ceil(log2(TMO+1)) bits wide and SHALL saturate at TMO; it SHALL never wrap.
REQ-034 Flags SHALL be sampled only in GRANT. A flag change during WAIT SHALL not affect the current operation.
REQ-035 A client that deasserts req_valid between arbitration and grant SHALL still be served.

Reset
REQ-036 On rst:
  - state = IDLE, rr_ptr = 0, timeout counter = 0, err_flag = 0;
  - req_ready, rsp_valid, q_enq, q_deq = 0;
  - rsp_data, q_din = 0.
REQ-037 rst mid-operation SHALL abandon the operation with no rsp_valid. A late q_done after reset SHALL be ignored.

Verification
REQ-038 Single enqueue: client 2 enq 0x5A with the queue not full.
  - Expect req_ready[2] at t+1, q_enq with q_din = 0x5A at t+2.
  - After q_done, expect rsp_valid[2] the next cycle with rsp_err = 0.
REQ-039 Round-robin with 4 clients: all 4 hold requests continuously from reset.
  - Expected grant order is 0, 1, 2, 3, 0.
  - No client is granted twice before the others are granted.
REQ-040 Boundaries:
  - Dequeue while q_empty = 1: rsp_err = 1, no q_deq pulse.
  - Enqueue while q_full = 1: rsp_err = 1, no q_enq pulse.
REQ-041 Dequeue data: q_done with q_dout = 0x11 arrives 7 cycles after q_deq. Expect rsp_data = 0x11 with rsp_valid on the following cycle.
REQ-042 Timeout: q_done withheld with TMO = 255. Expect rsp_err = 1 exactly 256 cycles after q_enq, then return to IDLE.
REQ-043 Reset in WAIT: assert rst during WAIT, then pulse q_done after reset. Expect no rsp_valid and all outputs 0.

Source files
------------

// File: rtl/quickq_req_arbiter.sv
// Round-robin arbiter that lets N clients share one QuickQ controller.
// Exactly one queue operation is in flight at a time; every accepted request ends in one rsp_valid strobe.
module quickq_req_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_op,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           q_enq,
    output logic           q_deq,
    output logic [W-1:0]   q_din,
    input  logic           q_done,
    input  logic [W-1:0]   q_dout,
    input  logic           q_full,
    input  logic           q_empty,
    output logic [2:0]     dbg_state
);

    // Handshake: a client holds req_valid/req_op/req_data until it sees its
    // one-cycle req_ready strobe; completion is a one-cycle rsp_valid strobe.
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win_idx;
    logic            win_op;
    logic [W-1:0]    din_r;
    logic [CW-1:0]   tmo_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            tmo_hit;
    logic            err_flag;
    logic            reject;
    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   ptr_nxt;
    logic [IW:0]     sum;

    // Round-robin search starting at rr_ptr, wrapping from N-1 to 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        sum       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            if (!arb_found && req_valid[sum[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = sum[IW-1:0];
            end
        end
    end

    assign ptr_nxt = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;
    assign reject  = win_op ? q_empty : q_full;
    // Counter saturates at TMO; the abort fires on the cycle it would reach TMO.
    assign cnt_inc = (tmo_cnt == CW'(TMO)) ? tmo_cnt : tmo_cnt + 1'b1;
    assign tmo_hit = (cnt_inc == CW'(TMO));

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_found) state_nxt = S_GRANT;
            S_GRANT: state_nxt = reject ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (q_done || tmo_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            win_idx  <= '0;
            win_op   <= 1'b0;
            din_r    <= '0;
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        win_idx <= arb_idx;
                        win_op  <= req_op[arb_idx];
                        din_r   <= req_data[arb_idx*W +: W];
                        rr_ptr  <= ptr_nxt;
                    end
                end
                S_GRANT: begin
                    // Occupancy flags matter only here; later changes are ignored.
                    if (reject) begin
                        err_flag <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        err_flag <= 1'b0;
                    end
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= cnt_inc;
                    if (q_done) begin
                        err_flag <= 1'b0;
                        rsp_data <= win_op ? q_dout : '0;
                    end else if (tmo_hit) begin
                        err_flag <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        q_enq     = 1'b0;
        q_deq     = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            S_GRANT: req_ready[win_idx] = 1'b1;
            S_ISSUE: begin
                q_enq = ~win_op;
                q_deq = win_op;
            end
            S_RESP: begin
                rsp_valid[win_idx] = 1'b1;
                rsp_err            = err_flag;
            end
            default: ;
        endcase
    end

    assign q_din     = din_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_quickq_req_arbiter.sv
// Directed and randomized bench for quickq_req_arbiter, checked against a
// transaction-level model of the round-robin and completion rules.
module tb_quickq_req_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_op;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_data, q_din, q_dout;
    logic           rsp_err, q_enq, q_deq, q_done, q_full, q_empty;
    logic [2:0]     dbg_state;

    quickq_req_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .q_enq(q_enq), .q_deq(q_deq), .q_din(q_din),
        .q_done(q_done), .q_dout(q_dout), .q_full(q_full), .q_empty(q_empty),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_rr = 0;
    bit cl_valid[N];
    logic cl_op[N];
    logic [W-1:0] cl_data[N];
    logic [W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = cl_valid[i];
            req_op[i] = cl_op[i];
            req_data[i*W +: W] = cl_data[i];
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (cl_valid[(exp_rr + k) % N])
                return (exp_rr + k) % N;
        end
        return -1;
    endfunction

    // One full transaction from the current idle cycle to the cycle after its response.
    task automatic run_txn(input int lat, input logic [W-1:0] dout, input bit withhold,
                           output int win, output int wait_cyc);
        int exp_w;
        int cyc;
        bit rej;
        logic op;
        logic [W-1:0] d;
        exp_w = model_winner();
        win = exp_w;
        wait_cyc = 0;
        while (req_ready == '0 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        if (req_ready == '0) begin
            tests++;
            fails++;
            $error("FAIL grant_wait: observed no req_ready expected client %0d", exp_w);
            return;
        end
        check("grant_onehot", 32'(req_ready), 32'(1 << exp_w));
        op = cl_op[exp_w];
        d = cl_data[exp_w];
        exp_rr = (exp_w + 1) % N;
        cl_valid[exp_w] = 1'b0;
        drive_reqs();
        rej = op ? q_empty : q_full;
        exp_q.push_back((rej || !op || withhold) ? '0 : dout);
        tick();
        if (rej) begin
            check("no_cmd_on_reject", {30'd0, q_enq, q_deq}, 32'd0);
        end else begin
            check("cmd_pulse", {30'd0, q_enq, q_deq}, {30'd0, ~op, op});
            if (!op)
                check("q_din", 32'(q_din), 32'(d));
            if (withhold) begin
                cyc = 0;
                while (rsp_valid == '0 && cyc < 400) begin
                    tick();
                    cyc++;
                end
                check("timeout_latency", cyc, 256);
            end else begin
                for (int k = 1; k <= lat; k++) begin
                    tick();
                    q_full = 1'($urandom_range(0, 1));
                    q_empty = 1'($urandom_range(0, 1));
                    if (k < lat)
                        check("no_early_rsp", 32'(rsp_valid), 32'd0);
                    else begin
                        q_done = 1'b1;
                        q_dout = dout;
                    end
                end
                tick();
                q_done = 1'b0;
                q_dout = W'($urandom);
            end
        end
        check("rsp_valid", 32'(rsp_valid), 32'(1 << exp_w));
        check("rsp_err", 32'(rsp_err), 32'(rej || withhold));
        check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
        tick();
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {req_ready, rsp_valid, rsp_data, rsp_err, q_enq, q_deq, q_din},
              32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int win, wc;
        int order[5];
        bit any;
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        q_done = 1'b0;
        q_dout = '0;
        q_full = 1'b0;
        q_empty = 1'b0;
        for (int i = 0; i < N; i++) begin
            cl_valid[i] = 1'b0;
            cl_op[i] = 1'b0;
            cl_data[i] = '0;
        end
        drive_reqs();
        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        // Single enqueue from client 2.
        cl_valid[2] = 1'b1; cl_op[2] = 1'b0; cl_data[2] = 8'h5A;
        drive_reqs();
        run_txn(3, 8'h00, 1'b0, win, wc);
        check("grant_latency", wc, 1);

        // All four clients request continuously from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cl_valid[i] = 1'b1;
            cl_op[i] = 1'($urandom_range(0, 1));
            cl_data[i] = W'($urandom);
        end
        drive_reqs();
        tick();
        tick();
        rst = 1'b0;
        exp_rr = 0;
        for (int i = 0; i < 5; i++) begin
            q_full = 1'b0;
            q_empty = 1'b0;
            run_txn($urandom_range(1, 5), W'($urandom), 1'b0, win, wc);
            check("rr_order", win, order[i]);
            cl_valid[win] = 1'b1;
            drive_reqs();
        end
        for (int i = 0; i < N; i++) cl_valid[i] = 1'b0;
        drive_reqs();
        repeat (2) tick();

        // Dequeue while empty, enqueue while full.
        q_full = 1'b0; q_empty = 1'b1;
        cl_valid[1] = 1'b1; cl_op[1] = 1'b1; cl_data[1] = 8'h77;
        drive_reqs();
        run_txn(1, 8'h00, 1'b0, win, wc);
        q_full = 1'b1; q_empty = 1'b0;
        cl_valid[3] = 1'b1; cl_op[3] = 1'b0; cl_data[3] = 8'h99;
        drive_reqs();
        run_txn(1, 8'h00, 1'b0, win, wc);

        // Dequeue data returned 7 cycles after q_deq.
        q_full = 1'b0; q_empty = 1'b0;
        cl_valid[0] = 1'b1; cl_op[0] = 1'b1; cl_data[0] = 8'h3C;
        drive_reqs();
        run_txn(7, 8'h11, 1'b0, win, wc);

        // Timeout with q_done withheld.
        q_full = 1'b0; q_empty = 1'b0;
        cl_valid[2] = 1'b1; cl_op[2] = 1'b0; cl_data[2] = 8'hC3;
        drive_reqs();
        run_txn(1, 8'h00, 1'b1, win, wc);
        tick();
        check("idle_after_timeout", 32'(req_ready), 32'd0);

        // Stray q_done while idle.
        q_done = 1'b1;
        tick();
        q_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_done", {28'd0, rsp_valid}, 32'd0);
        end

        // Reset while waiting on the queue, then a late q_done.
        q_full = 1'b0; q_empty = 1'b0;
        cl_valid[1] = 1'b1; cl_op[1] = 1'b1; cl_data[1] = 8'hA5;
        drive_reqs();
        wc = 0;
        while (req_ready == '0 && wc < 20) begin
            tick();
            wc++;
        end
        check("rst_test_grant", 32'(req_ready), 32'b0010);
        cl_valid[1] = 1'b0;
        drive_reqs();
        tick();
        check("rst_test_deq", 32'(q_deq), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rr = 0;
        q_done = 1'b1;
        q_dout = 8'hEE;
        tick();
        q_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_all_zero("after_mid_reset");
            tick();
        end

        // Pointer restarts at 0 after reset: clients 1 and 3 pending, 1 wins.
        cl_valid[1] = 1'b1; cl_op[1] = 1'b0; cl_data[1] = 8'h21;
        cl_valid[3] = 1'b1; cl_op[3] = 1'b0; cl_data[3] = 8'h43;
        drive_reqs();
        run_txn(2, 8'h00, 1'b0, win, wc);
        check("rr_after_reset", win, 1);
        run_txn(2, 8'h00, 1'b0, win, wc);
        check("rr_next", win, 3);

        // Randomized traffic; pending requests are held until granted.
        for (int t = 0; t < 40; t++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!cl_valid[i] && $urandom_range(0, 1) == 1) begin
                    cl_valid[i] = 1'b1;
                    cl_op[i] = 1'($urandom_range(0, 1));
                    cl_data[i] = W'($urandom);
                end
                any = any | cl_valid[i];
            end
            if (!any) begin
                cl_valid[t % N] = 1'b1;
                cl_op[t % N] = 1'($urandom_range(0, 1));
                cl_data[t % N] = W'($urandom);
            end
            q_full = ($urandom_range(0, 3) == 0);
            q_empty = ($urandom_range(0, 3) == 0);
            drive_reqs();
            run_txn($urandom_range(1, 10), W'($urandom), 1'b0, win, wc);
        end
        for (int i = 0; i < N; i++) cl_valid[i] = 1'b0;
        drive_reqs();
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
